// File: rtl/search_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : search_pkg
//  Description : Shared definitions for the search arbiter slice. Holds the
//                default key and match-address widths and the arbiter state
//                type.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package search_pkg;

   localparam int C_RULE_WIDTH_DEF = 24;
   localparam int C_ADDR_WIDTH_DEF = 8;

   // Arbiter states. Encoding is fixed so waveforms from older builds still
   // decode the same way.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

endpackage
`default_nettype wire

// File: rtl/srch_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : srch_tag_fifo
//  Description : Small show-ahead FIFO that remembers which requester owns
//                each search outstanding in the search RAM. Results come back
//                in order, so the head entry always names the owner of the
//                next result.
//  Ports       : clk_i, rstn      clock / async active-low reset
//                push_i, push_data_i   write one tag (ignored when full)
//                pop_i             drop the head tag (ignored when empty)
//                head_o            tag at the head of the FIFO
//                count_o           number of tags held
//                empty_o           no tags held
//  Revision    : 1.0  initial release
// ============================================================================
module srch_tag_fifo #(
   parameter int C_WIDTH = 2,
   parameter int C_DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rstn,
   input  logic                     push_i,
   input  logic [C_WIDTH-1:0]       push_data_i,
   input  logic                     pop_i,
   output logic [C_WIDTH-1:0]       head_o,
   output logic [$clog2(C_DEPTH):0] count_o,
   output logic                     empty_o
);

   localparam int C_PTR_W = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
   localparam int C_CNT_W = $clog2(C_DEPTH) + 1;

   logic [C_WIDTH-1:0] mem_q [C_DEPTH];
   logic [C_WIDTH-1:0] mem_d [C_DEPTH];
   logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [C_CNT_W-1:0] count_q, count_d;
   logic               push_ok;
   logic               pop_ok;

   // Explicit wrap keeps the pointers correct for any depth, not only
   // depths that fill the pointer width.
   function automatic logic [C_PTR_W-1:0] ptr_inc(input logic [C_PTR_W-1:0] p);
      return (p == C_PTR_W'(C_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign push_ok = push_i && (count_q != C_CNT_W'(C_DEPTH));
   assign pop_ok  = pop_i && (count_q != '0);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data_i;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/search_arb.sv
`default_nettype none
// ============================================================================
//  Module      : search_arb
//  Description : Round-robin arbiter that funnels key searches from several
//                requesters into one search RAM and routes the in-order
//                results back to the requester that issued each search.
//  Ports       : clk_i, rstn           clock / async active-low reset
//                en_i                  arbitration enable
//                req_valid_i/key_i     per-requester search requests
//                req_ready_o           one-hot grant (combinational)
//                srch_o, srch_key_o    search strobe and key to the RAM
//                ram_busy_i            RAM cannot accept a search
//                res_vld_i/match_i/addr_i  in-order results from the RAM
//                rsp_vld_o/match_o/addr_o  result routed to its requester
//                busy_o                arbiter not idle
//                err_o                 sticky: result with nothing outstanding
//  Revision    : 1.0  initial release
// ============================================================================
module search_arb
   import search_pkg::*;
#(
   parameter int C_RULE_WIDTH = C_RULE_WIDTH_DEF,
   parameter int C_NUM_REQ    = 4,
   parameter int C_ADDR_WIDTH = C_ADDR_WIDTH_DEF,
   parameter int C_TAG_DEPTH  = 4
) (
   input  logic                              clk_i,
   input  logic                              rstn,
   input  logic                              en_i,
   input  logic [C_NUM_REQ-1:0]              req_valid_i,
   input  logic [C_NUM_REQ*C_RULE_WIDTH-1:0] req_key_i,
   output logic [C_NUM_REQ-1:0]              req_ready_o,
   output logic                              srch_o,
   output logic [C_RULE_WIDTH-1:0]           srch_key_o,
   input  logic                              ram_busy_i,
   input  logic                              res_vld_i,
   input  logic                              res_match_i,
   input  logic [C_ADDR_WIDTH-1:0]           res_addr_i,
   output logic [C_NUM_REQ-1:0]              rsp_vld_o,
   output logic                              rsp_match_o,
   output logic [C_ADDR_WIDTH-1:0]           rsp_addr_o,
   output logic                              busy_o,
   output logic                              err_o
);

   localparam int C_IDX_W = $clog2(C_NUM_REQ);
   localparam int C_CNT_W = $clog2(C_TAG_DEPTH) + 1;

   state_e                    state_q, state_d;
   logic [C_IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic                      srch_q, srch_d;
   logic [C_RULE_WIDTH-1:0]   srch_key_q, srch_key_d;
   logic [C_NUM_REQ-1:0]      rsp_vld_q, rsp_vld_d;
   logic                      rsp_match_q, rsp_match_d;
   logic [C_ADDR_WIDTH-1:0]   rsp_addr_q, rsp_addr_d;
   logic                      err_q, err_d;

   logic                      issue_ok;
   logic                      hi_found, lo_found;
   logic [C_IDX_W-1:0]        hi_idx, lo_idx;
   logic                      grant_vld;
   logic [C_IDX_W-1:0]        grant_idx;
   logic [C_RULE_WIDTH-1:0]   grant_key;
   logic                      xfer;

   logic                      fifo_pop;
   logic [C_IDX_W-1:0]        fifo_head;
   logic [C_CNT_W-1:0]        fifo_count;
   logic                      fifo_empty;

   // The full check uses the registered count only: a pop in the same cycle
   // does not open a slot until the next cycle.
   assign issue_ok = (state_q == ST_RUN) && !ram_busy_i &&
                     (fifo_count < C_CNT_W'(C_TAG_DEPTH));

   // Round-robin search split into two priority bands: requesters above
   // rr_ptr first (lowest index wins), then wrap to 0..rr_ptr. The last
   // granted requester lands in the lower band and so has lowest priority.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = 0; i < C_NUM_REQ; i++) begin
         if (req_valid_i[i]) begin
            if (C_IDX_W'(i) > rr_ptr_q) begin
               if (!hi_found) begin
                  hi_found = 1'b1;
                  hi_idx   = C_IDX_W'(i);
               end
            end else if (!lo_found) begin
               lo_found = 1'b1;
               lo_idx   = C_IDX_W'(i);
            end
         end
      end
      grant_vld = hi_found || lo_found;
      grant_idx = hi_found ? hi_idx : lo_idx;
   end

   // Grant decode and key select.
   always_comb begin
      req_ready_o = '0;
      grant_key   = '0;
      for (int i = 0; i < C_NUM_REQ; i++) begin
         if (grant_idx == C_IDX_W'(i)) begin
            req_ready_o[i] = issue_ok && grant_vld;
            grant_key      = req_key_i[i*C_RULE_WIDTH +: C_RULE_WIDTH];
         end
      end
   end

   // The granted requester is valid by construction, so ready alone marks
   // the transfer.
   assign xfer     = issue_ok && grant_vld;
   assign fifo_pop = res_vld_i && !fifo_empty;

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      srch_d      = xfer;
      srch_key_d  = srch_key_q;
      rsp_vld_d   = '0;
      rsp_match_d = rsp_match_q;
      rsp_addr_d  = rsp_addr_q;
      err_d       = err_q | (res_vld_i & fifo_empty);

      if (xfer) begin
         rr_ptr_d   = grant_idx;
         srch_key_d = grant_key;
      end

      if (fifo_pop) begin
         rsp_match_d = res_match_i;
         rsp_addr_d  = res_addr_i;
         for (int i = 0; i < C_NUM_REQ; i++) begin
            if (fifo_head == C_IDX_W'(i)) begin
               rsp_vld_d[i] = 1'b1;
            end
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (en_i) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!en_i) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (en_i) begin
               state_d = ST_RUN;
            end else if (fifo_empty) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= C_IDX_W'(C_NUM_REQ - 1);
         srch_q      <= 1'b0;
         srch_key_q  <= '0;
         rsp_vld_q   <= '0;
         rsp_match_q <= 1'b0;
         rsp_addr_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         srch_q      <= srch_d;
         srch_key_q  <= srch_key_d;
         rsp_vld_q   <= rsp_vld_d;
         rsp_match_q <= rsp_match_d;
         rsp_addr_q  <= rsp_addr_d;
         err_q       <= err_d;
      end
   end

   srch_tag_fifo #(
      .C_WIDTH (C_IDX_W),
      .C_DEPTH (C_TAG_DEPTH)
   ) u_tag_fifo (
      .clk_i       (clk_i),
      .rstn        (rstn),
      .push_i      (xfer),
      .push_data_i (grant_idx),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .count_o     (fifo_count),
      .empty_o     (fifo_empty)
   );

   assign srch_o      = srch_q;
   assign srch_key_o  = srch_key_q;
   assign rsp_vld_o   = rsp_vld_q;
   assign rsp_match_o = rsp_match_q;
   assign rsp_addr_o  = rsp_addr_q;
   assign busy_o      = (state_q != ST_IDLE);
   assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_search_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_search_arb
//  Description : Self-checking bench for search_arb. A queue-based reference
//                model tracks owner tags, the round-robin pointer and the
//                arbiter mode, and predicts every output each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_search_arb;

   localparam int C_N  = 4;
   localparam int C_W  = 24;
   localparam int C_AW = 8;
   localparam int C_D  = 4;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;

   logic                 clk_i = 1'b0;
   logic                 rstn  = 1'b1;
   logic                 en_i;
   logic [C_N-1:0]       req_valid_i;
   logic [C_N*C_W-1:0]   req_key_i;
   logic [C_N-1:0]       req_ready_o;
   logic                 srch_o;
   logic [C_W-1:0]       srch_key_o;
   logic                 ram_busy_i;
   logic                 res_vld_i;
   logic                 res_match_i;
   logic [C_AW-1:0]      res_addr_i;
   logic [C_N-1:0]       rsp_vld_o;
   logic                 rsp_match_o;
   logic [C_AW-1:0]      rsp_addr_o;
   logic                 busy_o;
   logic                 err_o;

   search_arb #(
      .C_RULE_WIDTH (C_W),
      .C_NUM_REQ    (C_N),
      .C_ADDR_WIDTH (C_AW),
      .C_TAG_DEPTH  (C_D)
   ) dut (
      .clk_i       (clk_i),
      .rstn        (rstn),
      .en_i        (en_i),
      .req_valid_i (req_valid_i),
      .req_key_i   (req_key_i),
      .req_ready_o (req_ready_o),
      .srch_o      (srch_o),
      .srch_key_o  (srch_key_o),
      .ram_busy_i  (ram_busy_i),
      .res_vld_i   (res_vld_i),
      .res_match_i (res_match_i),
      .res_addr_i  (res_addr_i),
      .rsp_vld_o   (rsp_vld_o),
      .rsp_match_o (rsp_match_o),
      .rsp_addr_o  (rsp_addr_o),
      .busy_o      (busy_o),
      .err_o       (err_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int             m_state;
   int             m_rr;
   int             m_tags[$];
   bit             m_err;
   logic           e_srch;
   logic [C_W-1:0] e_key;
   logic [C_N-1:0] e_rsp;
   logic           e_match;
   logic [C_AW-1:0] e_addr;

   // Grant seen from the DUT in the last stepped cycle
   logic [C_N-1:0] last_rdy;
   int             wait_x[C_N];

   task automatic check_val(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic clear_in();
      req_valid_i = '0;
      req_key_i   = '0;
      ram_busy_i  = 1'b0;
      res_vld_i   = 1'b0;
      res_match_i = 1'b0;
      res_addr_i  = '0;
   endtask

   task automatic set_key(input int i, input logic [C_W-1:0] k);
      req_key_i = req_key_i & ~((C_N*C_W)'({C_W{1'b1}}) << (i*C_W));
      req_key_i = req_key_i | ((C_N*C_W)'(k) << (i*C_W));
   endtask

   task automatic model_reset();
      m_state = M_IDLE;
      m_rr    = C_N - 1;
      m_tags.delete();
      m_err   = 1'b0;
      e_srch  = 1'b0;
      e_key   = '0;
      e_rsp   = '0;
      e_match = 1'b0;
      e_addr  = '0;
   endtask

   // Asynchronous reset applied mid-cycle; outputs checked while held.
   task automatic do_reset();
      rstn        = 1'b0;
      en_i        = 1'b1;
      req_valid_i = '1;
      #2;
      model_reset();
      check_val("rst_ready",  64'(req_ready_o), 64'(0));
      check_val("rst_srch",   64'(srch_o),      64'(0));
      check_val("rst_key",    64'(srch_key_o),  64'(0));
      check_val("rst_rspvld", 64'(rsp_vld_o),   64'(0));
      check_val("rst_match",  64'(rsp_match_o), 64'(0));
      check_val("rst_addr",   64'(rsp_addr_o),  64'(0));
      check_val("rst_err",    64'(err_o),       64'(0));
      check_val("rst_busy",   64'(busy_o),      64'(0));
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      clear_in();
      en_i = 1'b0;
      rstn = 1'b1;
   endtask

   // One clock cycle: inputs are already applied; compare every output
   // with the model, then advance the model across the coming edge.
   task automatic step();
      logic [C_N-1:0] exp_rdy;
      int g;
      int pre_size;
      int h;
      #2;
      check_val("srch_o",     64'(srch_o),     64'(e_srch));
      check_val("srch_key_o", 64'(srch_key_o), 64'(e_key));
      check_val("rsp_vld_o",  64'(rsp_vld_o),  64'(e_rsp));
      if (e_rsp != '0) begin
         check_val("rsp_match_o", 64'(rsp_match_o), 64'(e_match));
         check_val("rsp_addr_o",  64'(rsp_addr_o),  64'(e_addr));
      end
      check_val("busy_o", 64'(busy_o), 64'(m_state != M_IDLE));
      check_val("err_o",  64'(err_o),  64'(m_err));

      g = -1;
      if (m_state == M_RUN && !ram_busy_i && m_tags.size() < C_D) begin
         for (int k = 1; k <= C_N; k++) begin
            int i;
            i = (m_rr + k) % C_N;
            if (g < 0 && ((req_valid_i >> i) & C_N'(1)) != '0) g = i;
         end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy = C_N'(1) << g;
      check_val("req_ready_o", 64'(req_ready_o), 64'(exp_rdy));
      last_rdy = req_ready_o;

      pre_size = m_tags.size();
      e_srch   = (g >= 0);
      if (g >= 0) begin
         e_key = C_W'(req_key_i >> (g*C_W));
         m_rr  = g;
      end
      e_rsp = '0;
      if (res_vld_i) begin
         if (pre_size > 0) begin
            h       = m_tags.pop_front();
            e_rsp   = C_N'(1) << h;
            e_match = res_match_i;
            e_addr  = res_addr_i;
         end else begin
            m_err = 1'b1;
         end
      end
      if (g >= 0) m_tags.push_back(g);

      case (m_state)
         M_IDLE:  if (en_i) m_state = M_RUN;
         M_RUN:   if (!en_i) m_state = M_DRAIN;
         default: begin
            if (en_i) m_state = M_RUN;
            else if (pre_size == 0) m_state = M_IDLE;
         end
      endcase

      @(posedge clk_i); #1;
   endtask

   function automatic int onehot_idx(input logic [C_N-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < C_N; i++) if (v[i]) r = i;
      return r;
   endfunction

   initial begin
      int exp_order[5];
      clear_in();
      en_i     = 1'b0;
      last_rdy = '0;
      model_reset();
      #1;

      // Single request from requester 2
      do_reset();
      en_i = 1'b1;
      step();
      req_valid_i = 4'b0100;
      set_key(2, 24'h0101A5);
      step();
      check_val("t1_grant", 64'(last_rdy), 64'(4'b0100));
      req_valid_i = '0;
      check_val("t1_srch", 64'(srch_o), 64'(1));
      check_val("t1_key",  64'(srch_key_o), 64'(24'h0101A5));
      res_vld_i = 1'b1; res_match_i = 1'b1; res_addr_i = 8'h12;
      step();
      res_vld_i = 1'b0;
      check_val("t1_rsp_vld",   64'(rsp_vld_o),   64'(4'b0100));
      check_val("t1_rsp_match", 64'(rsp_match_o), 64'(1));
      check_val("t1_rsp_addr",  64'(rsp_addr_o),  64'(8'h12));
      step();

      // All requesters valid, results returned promptly
      do_reset();
      en_i = 1'b1;
      step();
      req_valid_i  = '1;
      exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2;
      exp_order[3] = 3; exp_order[4] = 0;
      for (int c = 0; c < 5; c++) begin
         res_vld_i = (m_tags.size() > 0);
         step();
         check_val("t2_order", 64'(last_rdy), 64'(C_N'(1) << exp_order[c]));
      end

      // Tag FIFO fills after four issues
      do_reset();
      en_i = 1'b1;
      step();
      req_valid_i = '1;
      for (int c = 0; c < 4; c++) step();
      step();
      check_val("t3_full_a", 64'(last_rdy), 64'(0));
      step();
      check_val("t3_full_b", 64'(last_rdy), 64'(0));
      res_vld_i = 1'b1;
      step();
      check_val("t3_pop_same", 64'(last_rdy), 64'(0));
      res_vld_i = 1'b0;
      step();
      check_val("t3_resume", 64'(last_rdy), 64'(4'b0001));

      // RAM busy for three cycles mid-stream
      do_reset();
      en_i = 1'b1;
      step();
      req_valid_i = '1;
      for (int c = 0; c < 12; c++) begin
         ram_busy_i = (c >= 4 && c <= 6);
         res_vld_i  = (m_tags.size() > 0) && c[0];
         step();
         if (c >= 4 && c <= 6) check_val("t4_no_srch", 64'(srch_o), 64'(0));
      end
      ram_busy_i = 1'b0;

      // Disable with two outstanding searches
      do_reset();
      en_i = 1'b1;
      step();
      req_valid_i = 4'b0011;
      step();
      step();
      req_valid_i = '0;
      en_i = 1'b0;
      step();
      check_val("t5_drain_busy", 64'(busy_o), 64'(1));
      res_vld_i = 1'b1; res_addr_i = 8'h21; res_match_i = 1'b0;
      step();
      check_val("t5_rsp0", 64'(rsp_vld_o), 64'(4'b0001));
      res_addr_i = 8'h22; res_match_i = 1'b1;
      step();
      check_val("t5_rsp1", 64'(rsp_vld_o), 64'(4'b0010));
      res_vld_i = 1'b0;
      step();
      check_val("t5_idle", 64'(busy_o), 64'(0));
      step();

      // Result with nothing outstanding; reset discarding tags
      do_reset();
      res_vld_i = 1'b1;
      step();
      res_vld_i = 1'b0;
      check_val("t6_err",    64'(err_o),     64'(1));
      check_val("t6_no_rsp", 64'(rsp_vld_o), 64'(0));
      step();
      do_reset();
      check_val("t6_err_clr", 64'(err_o), 64'(0));
      en_i = 1'b1;
      step();
      req_valid_i = 4'b0001;
      step();
      step();
      do_reset();
      res_vld_i = 1'b1;
      step();
      res_vld_i = 1'b0;
      check_val("t6_err_after_rst", 64'(err_o), 64'(1));
      do_reset();

      // Randomized traffic
      for (int i = 0; i < C_N; i++) wait_x[i] = 0;
      for (int c = 0; c < 3000; c++) begin
         int gi;
         en_i       = ($urandom_range(0, 11) != 0);
         ram_busy_i = ($urandom_range(0, 4) == 0);
         for (int i = 0; i < C_N; i++) begin
            if (!req_valid_i[i] && $urandom_range(0, 2) == 0) begin
               req_valid_i[i] = 1'b1;
               set_key(i, C_W'($urandom));
            end
         end
         res_vld_i   = (m_tags.size() > 0) && ($urandom_range(0, 1) == 1);
         res_match_i = 1'($urandom);
         res_addr_i  = C_AW'($urandom);
         step();
         gi = onehot_idx(last_rdy);
         if (gi >= 0) begin
            for (int i = 0; i < C_N; i++) begin
               if (i == gi) begin
                  check_val("no_starve", 64'(wait_x[i] < C_N), 64'(1));
                  wait_x[i] = 0;
               end else if (req_valid_i[i]) begin
                  wait_x[i]++;
               end
            end
            req_valid_i[gi] = 1'b0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/search_arb.md
SEARCH_ARB -- requirements
Module: search_arb

Interface
REQ-001 Parameter C_RULE_WIDTH, default 24, key width in bits.
REQ-002 Parameter C_NUM_REQ, default 4, number of key requesters (2..8).
REQ-003 Parameter C_ADDR_WIDTH, default 8, match-address width returned by the search RAM.
REQ-004 Parameter C_TAG_DEPTH, default 4, maximum searches outstanding in the search RAM (power of 2).
REQ-005 clk_i  in  1  clock; all logic on the rising edge.
REQ-006 rstn  in  1  reset, asynchronous, active-low.
REQ-007 en_i  in  1  level; 1 = arbitration enabled.
REQ-008 req_valid_i  in  C_NUM_REQ  per-requester search request.
REQ-009 req_key_i  in  C_NUM_REQ*C_RULE_WIDTH  per-requester key; requester i occupies bits [i*W +: W].
REQ-010 req_ready_o  out  C_NUM_REQ  one-hot grant; a transfer occurs when valid and ready are both 1.
REQ-011 srch_o  out  1  one-cycle search strobe to the search RAM.
REQ-012 srch_key_o  out  C_RULE_WIDTH  key qualified by srch_o.
REQ-013 ram_busy_i  in  1  search RAM is updating; no new search may be issued.
REQ-014 res_vld_i, res_match_i, res_addr_i  in  1/1/C_ADDR_WIDTH  in-order search result from the RAM.
REQ-015 rsp_vld_o  out  C_NUM_REQ  one-hot, one cycle; routes the result to the originating requester.
REQ-016 rsp_match_o, rsp_addr_o  out  1/C_ADDR_WIDTH  result qualified by rsp_vld_o.
REQ-017 busy_o, err_o  out  1/1  state is not IDLE; sticky protocol error.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and DRAIN: IDLE->RUN on en_i=1; RUN->DRAIN on en_i=0; DRAIN->IDLE when the tag FIFO is empty; DRAIN->RUN if en_i returns to 1.
REQ-019 Issue condition: state RUN, ram_busy_i=0 and tag count < C_TAG_DEPTH; a same-cycle pop does not relax the full check.
REQ-020 When the issue condition holds, req_ready_o SHALL be combinational and assert exactly one bit: the first valid requester at or after rr_ptr+1 (mod C_NUM_REQ); otherwise req_ready_o = 0.
REQ-021 rr_ptr SHALL update to the granted index only on a transfer.
REQ-022 On a transfer in cycle N, the block SHALL set srch_o=1 and srch_key_o=granted key in cycle N+1, and push the granted index into the tag FIFO.
REQ-023 srch_o SHALL be 0 in every cycle not following a transfer; srch_key_o holds its last value.
REQ-024 On res_vld_i with the FIFO non-empty, the block SHALL pop the head index and drive rsp_vld_o[index]=1 with registered res_match_i and res_addr_i one cycle later.
REQ-025 Push and pop in the same cycle SHALL leave the count unchanged.
REQ-026 res_vld_i with an empty FIFO SHALL set err_o, produce no rsp_vld_o and leave the count at 0.
REQ-027 err_o SHALL clear only on reset.
REQ-028 Results arriving in IDLE or DRAIN SHALL still be routed.
REQ-029 ram_busy_i asserting mid-stream SHALL block the next grant only; outstanding results are unaffected.
REQ-030 A requester that holds valid SHALL be granted within C_NUM_REQ transfers (no starvation).

Reset
REQ-031 On rstn=0 the block SHALL asynchronously set: state IDLE, rr_ptr = C_NUM_REQ-1 (requester 0 has first priority), tag FIFO empty, srch_o 0, srch_key_o 0, rsp_vld_o 0, rsp_match_o 0, rsp_addr_o 0, err_o 0, busy_o 0.
REQ-032 While rstn=0, req_ready_o SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL discard all outstanding tags; results arriving after reset release with an empty FIFO follow REQ-026.

Structure
REQ-034 The shared package search_pkg SHALL hold the C_RULE_WIDTH and C_ADDR_WIDTH defaults and the state enum typedef.
REQ-035 The tag FIFO SHALL be the sub-module srch_tag_fifo (width clog2(C_NUM_REQ), depth C_TAG_DEPTH, count output).
REQ-036 Arbitration and FSM logic SHALL reside in search_arb.

Verification
REQ-037 Single request: en_i=1, req 2 key 0x0101A5 -> srch_o in the next cycle with key 0x0101A5; res_vld_i with match=1, addr=0x12 -> rsp_vld_o=4'b0100, rsp_addr_o=0x12 one cycle later.
REQ-038 All four requesters valid continuously after reset -> grant order 0,1,2,3,0, one per cycle.
REQ-039 Five issues with no result and C_TAG_DEPTH=4 -> fourth issue accepted, req_ready_o=0 thereafter; one res_vld_i -> a grant resumes the cycle after.
REQ-040 ram_busy_i=1 for 3 cycles during a stream -> no srch_o in those cycles; ordering is preserved.
REQ-041 en_i drops with 2 searches outstanding -> DRAIN, both rsp_vld_o delivered, then IDLE and busy_o=0.
REQ-042 res_vld_i after reset with no issues -> err_o=1, rsp_vld_o=0; rstn pulse -> err_o=0.
